// File: rtl/real_sweep_gen.sv
// real_sweep_gen: clocked fixed-point linear sweep source with valid/ready output.
// Emits start_q, start_q+step_q, ... while the value stays <= stop_q, one sample
// per accepted handshake, then pulses done for one cycle.
// Optional build macro SWEEP_BIDIR_EN: after the top of the ramp the sweep turns
// around and steps back down to start_q before finishing.
//
// Output format: signed OUT_WIDTH-bit value, LSB weight 2**OUT_EXPONENT,
// magnitude limited to out_range. Constants are rounded to this format at
// elaboration and saturated to its range.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for go; out holds the last value emitted
//   RUN    | offering ascending samples, advancing on each handshake
//   RUN_DN | (SWEEP_BIDIR_EN only) offering descending samples
//   DONE   | one-cycle done pulse, then back to IDLE

module real_sweep_gen #(
    parameter real start_val    = 0.0,
    parameter real stop_val     = 1.0,
    parameter real step_val     = 0.1,
    parameter int  IDX_WIDTH    = 16,
    parameter real out_range    = 10.0,
    parameter int  OUT_WIDTH    = 16,
    parameter int  OUT_EXPONENT = -10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        go,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_WIDTH-1:0]        idx,
    output logic                        busy,
    output logic                        done
);

    localparam real    LSB_SCALE = 2.0 ** (-OUT_EXPONENT);
    localparam longint FMT_MAX   = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
    // Largest magnitude the format can carry: the declared range, capped by the word width.
    localparam real    LIMIT_R   = (out_range * LSB_SCALE < real'(FMT_MAX)) ?
                                   out_range * LSB_SCALE : real'(FMT_MAX);

    // Round-to-nearest quantization with saturation, evaluated only at elaboration.
    function automatic longint quant(input real v);
        real s;
        s = v * LSB_SCALE;
        if (s > LIMIT_R)
            s = LIMIT_R;
        else if (s < -LIMIT_R)
            s = -LIMIT_R;
        if (s >= 0.0)
            return longint'($rtoi(s + 0.5));
        else
            return -longint'($rtoi(-s + 0.5));
    endfunction

    localparam longint START_L = quant(start_val);
    localparam longint STOP_L  = quant(stop_val);
    localparam longint STEP_L  = quant(step_val);

    localparam logic signed [OUT_WIDTH-1:0] START_Q = OUT_WIDTH'(START_L);

    // One guard bit so start/stop/step sums cannot wrap before the compare.
    localparam logic signed [OUT_WIDTH:0] STEP_X = (OUT_WIDTH + 1)'(STEP_L);
    localparam logic signed [OUT_WIDTH:0] STOP_X = (OUT_WIDTH + 1)'(STOP_L);
`ifdef SWEEP_BIDIR_EN
    localparam logic signed [OUT_WIDTH:0] START_X = (OUT_WIDTH + 1)'(START_L);
`endif

    localparam logic [IDX_WIDTH-1:0] IDX_ONE = {{(IDX_WIDTH - 1){1'b0}}, 1'b1};

    // Elaboration-time sanity checks on the quantized constants.
    if (STEP_L <= 0) begin : g_bad_step
        $error("real_sweep_gen: step_val quantizes to a non-positive step");
    end
    if (STOP_L < START_L) begin : g_bad_order
        $error("real_sweep_gen: stop_val quantizes below start_val");
    end
    if (start_val * LSB_SCALE > LIMIT_R || start_val * LSB_SCALE < -LIMIT_R) begin : g_sat_start
        $warning("real_sweep_gen: start_val outside output range, saturated");
    end
    if (stop_val * LSB_SCALE > LIMIT_R || stop_val * LSB_SCALE < -LIMIT_R) begin : g_sat_stop
        $warning("real_sweep_gen: stop_val outside output range, saturated");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE   = 2'd2
`ifdef SWEEP_BIDIR_EN
        ,
        RUN_DN = 2'd3
`endif
    } state_t;

    state_t state;

    logic signed [OUT_WIDTH:0] out_x;
    logic signed [OUT_WIDTH:0] nxt_up;
`ifdef SWEEP_BIDIR_EN
    logic signed [OUT_WIDTH:0] nxt_dn;
`endif
    logic                      accept;

    // Candidate next values, computed one bit wider than the output.
    always_comb begin
        out_x  = {out[OUT_WIDTH-1], out};
        nxt_up = out_x + STEP_X;
`ifdef SWEEP_BIDIR_EN
        nxt_dn = out_x - STEP_X;
`endif
        accept = out_valid & out_ready;
    end

    // Sweep sequencer; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (go) begin
                        out       <= START_Q;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (nxt_up <= STOP_X) begin
                            out <= nxt_up[OUT_WIDTH-1:0];
                            idx <= idx + IDX_ONE;
`ifdef SWEEP_BIDIR_EN
                        end else if (nxt_dn >= START_X) begin
                            // Turn around without repeating the top sample.
                            out   <= nxt_dn[OUT_WIDTH-1:0];
                            idx   <= idx + IDX_ONE;
                            state <= RUN_DN;
`endif
                        end else begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
`ifdef SWEEP_BIDIR_EN
                RUN_DN: begin
                    if (accept) begin
                        if (nxt_dn >= START_X) begin
                            out <= nxt_dn[OUT_WIDTH-1:0];
                            idx <= idx + IDX_ONE;
                        end else begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
`endif
                DONE: begin
                    // go is deliberately not looked at here.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
